// File: rtl/truth_table_scanner_pkg.sv
// Shared types and defaults for the truth-table scanner: FSM state encoding,
// counter width and the table-width helper.
package truth_table_scanner_pkg;

  localparam int N_IN_DEF   = 3;
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W      = 4;  // holds SETTLE-1 for SETTLE up to 15

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int table_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle-window counter: clears on clr, counts while en, and flags terminal
// count when the current vector has been held for SETTLE cycles.
module settle_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks {A,B,C} through every code, samples the gate
// output after a settle window and packs the result into table_q.
// Define TT_SCANNER_CHECK_EN to add the golden-table compare (expected,
// mismatch, err_cnt).
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        vec,
  input  logic                   dut_out,
  output logic [(1<<N_IN)-1:0]   table_q,
  output logic                   busy,
  output logic                   done
`ifdef TT_SCANNER_CHECK_EN
  ,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic                   mismatch,
  output logic [N_IN:0]          err_cnt
`endif
);

  localparam int TW = table_width(N_IN);

  state_t          state;
  state_t          state_next;
  logic [N_IN-1:0] idx;
  logic            tc;
  logic            last;
  logic            accept;

  // A start arriving while the previous done pulse is still up is dropped,
  // so a held start re-arms one cycle after done.
  assign accept = (state == IDLE) && start && !done;
  assign last   = (idx == N_IN'(TW - 1));
  assign vec    = idx;
  assign busy   = (state == DRIVE) || (state == SAMPLE);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .clr ((state == IDLE) || (state == SAMPLE)),
    .en  (state == DRIVE),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   if (tc)     state_next = SAMPLE;
      SAMPLE:  state_next = last ? DONE : DRIVE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      table_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept) begin
        idx     <= '0;
        table_q <= '0;
      end else if (state == SAMPLE) begin
        table_q[idx] <= dut_out;
        if (!last) idx <= idx + N_IN'(1);
      end
    end
  end

`ifdef TT_SCANNER_CHECK_EN
  // err_cnt accumulates bit differences as each sample lands; mismatch is
  // taken from the finished table so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (accept) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (state == SAMPLE) begin
      err_cnt <= err_cnt + (N_IN+1)'(dut_out != expected[idx]);
    end else if (state == DONE) begin
      mismatch <= (table_q != expected);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: gate models drive dut_out from
// vec, and a timeline model predicts busy/vec/done/table_q every cycle.
module tb_truth_table_scanner;

  localparam int N_IN   = 3;
  localparam int SETTLE = 2;
  localparam int TW     = 1 << N_IN;
  localparam int LAT    = 1 + TW * (SETTLE + 1);

  localparam int K_ANDOR = 0;
  localparam int K_MUX   = 1;
  localparam int K_RAND  = 2;
  localparam int K_XGATE = 3;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            start = 1'b0;
  logic [N_IN-1:0] vec;
  logic            dut_out;
  logic [TW-1:0]   table_q;
  logic            busy;
  logic            done;
`ifdef TT_SCANNER_CHECK_EN
  logic [TW-1:0]   expected = '0;
  logic            mismatch;
  logic [N_IN:0]   err_cnt;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  int            gate_kind = K_ANDOR;
  logic [TW-1:0] rand_tt = '0;

  always #5 clk = ~clk;

  truth_table_scanner #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vec      (vec),
    .dut_out  (dut_out),
    .table_q  (table_q),
    .busy     (busy),
    .done     (done)
`ifdef TT_SCANNER_CHECK_EN
    ,
    .expected (expected),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
`endif
  );

  function automatic logic gate_fn(input int kind, input logic [TW-1:0] tt,
                                   input logic [N_IN-1:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    case (kind)
      K_ANDOR: return c ? (a | b) : (a & b);
      K_MUX:   return c ? b : a;
      K_RAND:  return tt[v];
      default: return (v == 3'd5) ? 1'bx : 1'b0;
    endcase
  endfunction

  assign dut_out = gate_fn(gate_kind, rand_tt, vec);

  function automatic logic [TW-1:0] ref_table(input int kind, input logic [TW-1:0] tt);
    logic [TW-1:0] t;
    for (int i = 0; i < TW; i++) t[i] = gate_fn(kind, tt, N_IN'(i));
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Start a scan at edge 0 and check every cycle through edge LAT+2.
  task automatic run_scan(input int kind, input logic [TW-1:0] tt,
                          input logic [TW-1:0] exp_in, input int pulse_at,
                          input bit hold);
    logic [TW-1:0] want;
    int            vexp;
    gate_kind = kind;
    rand_tt   = tt;
    want      = ref_table(kind, tt);
`ifdef TT_SCANNER_CHECK_EN
    expected  = exp_in;
`else
    if (exp_in === 'x) $display("note: undefined expected table");
`endif
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = hold;
    check("busy_k0", 32'(busy), 32'd1);
    check("vec_k0", 32'(vec), 32'd0);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk);
      #1;
      start = hold || (k == pulse_at);
      vexp = k / (SETTLE + 1);
      if (vexp > TW - 1) vexp = TW - 1;
      if (hold && k == LAT + 2) vexp = 0;
      check($sformatf("busy_k%0d", k), 32'(busy),
            32'((k < LAT - 1) || (hold && k == LAT + 2)));
      check($sformatf("done_k%0d", k), 32'(done), 32'(k == LAT));
      check($sformatf("vec_k%0d", k), 32'(vec), 32'(vexp));
      if (k == LAT) begin
        check("table_q", 32'(table_q), 32'(want));
`ifdef TT_SCANNER_CHECK_EN
        if (kind != K_XGATE) begin
          check("mismatch", 32'(mismatch), 32'(want != exp_in));
          check("err_cnt", 32'(err_cnt), 32'($countones(want ^ exp_in)));
        end
`endif
      end
    end
    start = 1'b0;
    if (hold) repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [TW-1:0] tt;
    logic [TW-1:0] ex;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    check("rst_table", 32'(table_q), 32'd0);
`ifdef TT_SCANNER_CHECK_EN
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

    run_scan(K_ANDOR, '0, 8'hE8, 0, 1'b0);
    check("andor_table", 32'(table_q), 32'h0000_00E8);
`ifdef TT_SCANNER_CHECK_EN
    run_scan(K_ANDOR, '0, 8'hD8, 0, 1'b0);
    check("andor_vs_d8_err", 32'(err_cnt), 32'd2);
`endif

    run_scan(K_MUX, '0, 8'hD8, 0, 1'b0);
    check("mux_table", 32'(table_q), 32'h0000_00D8);

    // Second start while busy must not disturb the timeline.
    run_scan(K_ANDOR, '0, 8'hE8, 7, 1'b0);

    // Reset in mid-scan discards the partial table.
    gate_kind = K_RAND;
    rand_tt   = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("partial_table", 32'(table_q), 32'h0000_0007);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_table", 32'(table_q), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vec", 32'(vec), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    run_scan(K_ANDOR, '0, 8'hE8, 0, 1'b0);

    // Held start re-arms only after the done pulse has dropped.
    run_scan(K_MUX, '0, 8'hD8, 0, 1'b1);

    // An undriven gate output propagates into its table bit.
    run_scan(K_XGATE, '0, 8'h00, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      tt = TW'($urandom);
      ex = (r % 2 == 0) ? tt : TW'($urandom);
      run_scan(K_RAND, tt, ex, (r == 3) ? 12 : 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
